// File: rtl/cpu_speed_ctrl.sv
// CPU speed-mode selector: synchronises and debounces the speed switch, holds mode 0
// through boot and FORCE_SLOW, and hot-switches the turbo divider only at bus-idle low-phase ends.
module cpu_speed_ctrl #(
  parameter int                          SEL_W          = 2,
  parameter int                          NUM_MODES      = 2**SEL_W,
  parameter logic [NUM_MODES*16-1:0]     HALF_PERIODS   = {16'd1, 16'd3, 16'd2, 16'd0},
  parameter int                          DEBOUNCE_LIMIT = 2000000,
  parameter int                          BOOT_LIMIT     = 300000000,
  parameter int                          CNT_W          = 30
) (
  input  logic             C100M,
  input  logic             RESET_n,
  input  logic [SEL_W-1:0] SW_IN,
  input  logic             AS_CPU_n,
  input  logic             DTACK_CPU_n,
  input  logic             FORCE_SLOW,
  output logic [SEL_W-1:0] CPU_SPEED,
  output logic             TURBO_CLK,
  output logic             BOOT_DONE,
  output logic             SWITCH_PENDING
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] BOOT_MAX = CNT_W'(BOOT_LIMIT);

  function automatic logic [15:0] half_of(input logic [SEL_W-1:0] mode);
    return HALF_PERIODS[{mode, 4'b0000} +: 16];
  endfunction

  logic [SEL_W-1:0] sync1_q, sync1_d;
  logic [SEL_W-1:0] sync2_q, sync2_d;
  logic [SEL_W-1:0] sw_state_q, sw_state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic             boot_done_q, boot_done_d;
  logic [SEL_W-1:0] cpu_speed_q, cpu_speed_d;
  logic [15:0]      div_cnt_q, div_cnt_d;
  logic             turbo_q, turbo_d;
  logic             pending_q, pending_d;

  logic [SEL_W-1:0] target;
  logic [15:0]      cur_half;
  logic             at_wrap;
  logic             bus_idle;
  logic             commit_ok;

  // NOTE: every _d and helper gets a default at the top of the block so no path infers a latch.
  always_comb begin
    sync1_d     = SW_IN;
    sync2_d     = sync1_q;
    sw_state_d  = sw_state_q;
    db_cnt_d    = '0;
    cpu_speed_d = cpu_speed_q;
    div_cnt_d   = div_cnt_q;
    turbo_d     = turbo_q;

    // Count only while the synchronised switch differs from the accepted state and did not
    // just move; a change restarts the count.
    if (sync2_q != sw_state_q && sync1_q == sync2_q) begin
      if (db_cnt_q == DB_LAST) begin
        sw_state_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    boot_cnt_d  = (boot_cnt_q == BOOT_MAX) ? boot_cnt_q : boot_cnt_q + 1'b1;
    boot_done_d = boot_done_q | (boot_cnt_d == BOOT_MAX);

    target = sw_state_q;
    if (!boot_done_q || FORCE_SLOW || half_of(sw_state_q) == 16'd0) begin
      target = '0;
    end

    cur_half  = half_of(cpu_speed_q);
    at_wrap   = (div_cnt_q >= cur_half - 16'd1);
    bus_idle  = AS_CPU_n & DTACK_CPU_n;
    commit_ok = bus_idle && (cpu_speed_q == '0 || (!turbo_q && at_wrap));

    // A commit restarts the divider with TURBO_CLK low, so the first rise of the new mode
    // lands a full half-period later and no runt pulse reaches the CPU clock mux.
    if (commit_ok && target != cpu_speed_q) begin
      cpu_speed_d = target;
      div_cnt_d   = '0;
      turbo_d     = 1'b0;
    end else if (cpu_speed_q == '0) begin
      div_cnt_d = '0;
      turbo_d   = 1'b0;
    end else if (at_wrap) begin
      div_cnt_d = '0;
      turbo_d   = ~turbo_q;
    end else begin
      div_cnt_d = div_cnt_q + 16'd1;
    end

    pending_d = (target != cpu_speed_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge C100M or negedge RESET_n) begin
    if (!RESET_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sw_state_q  <= '0;
      db_cnt_q    <= '0;
      boot_cnt_q  <= '0;
      boot_done_q <= 1'b0;
      cpu_speed_q <= '0;
      div_cnt_q   <= '0;
      turbo_q     <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sw_state_q  <= sw_state_d;
      db_cnt_q    <= db_cnt_d;
      boot_cnt_q  <= boot_cnt_d;
      boot_done_q <= boot_done_d;
      cpu_speed_q <= cpu_speed_d;
      div_cnt_q   <= div_cnt_d;
      turbo_q     <= turbo_d;
      pending_q   <= pending_d;
    end
  end

  assign CPU_SPEED      = cpu_speed_q;
  assign TURBO_CLK      = turbo_q;
  assign BOOT_DONE      = boot_done_q;
  assign SWITCH_PENDING = pending_q;

endmodule

// File: tb/tb_cpu_speed_ctrl.sv
// Scoreboard bench for cpu_speed_ctrl: two instances (all modes enabled / mode 2 disabled)
// driven identically and compared every cycle against an arithmetic reference model.
module tb_cpu_speed_ctrl;

  localparam int          DB_LIM   = 8;
  localparam int          BOOT_LIM = 20;
  // Mode 1: h=3, mode 2: h=2, mode 3: h=1.
  localparam logic [63:0] HP_A = {16'd1, 16'd2, 16'd3, 16'd0};
  // Same, but mode 2 disabled.
  localparam logic [63:0] HP_B = {16'd1, 16'd0, 16'd3, 16'd0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sw_in = 2'd0;
  logic       as_n = 1'b1;
  logic       dtack_n = 1'b1;
  logic       force_slow = 1'b0;

  logic [1:0] speed_a, speed_b;
  logic       turbo_a, turbo_b, boot_a, boot_b, pend_a, pend_b;

  always #5 clk = ~clk;

  cpu_speed_ctrl #(.SEL_W(2), .HALF_PERIODS(HP_A), .DEBOUNCE_LIMIT(DB_LIM),
                   .BOOT_LIMIT(BOOT_LIM), .CNT_W(30)) u_dut_a (
    .C100M(clk), .RESET_n(rst_n), .SW_IN(sw_in), .AS_CPU_n(as_n), .DTACK_CPU_n(dtack_n),
    .FORCE_SLOW(force_slow), .CPU_SPEED(speed_a), .TURBO_CLK(turbo_a),
    .BOOT_DONE(boot_a), .SWITCH_PENDING(pend_a));

  cpu_speed_ctrl #(.SEL_W(2), .HALF_PERIODS(HP_B), .DEBOUNCE_LIMIT(DB_LIM),
                   .BOOT_LIMIT(BOOT_LIM), .CNT_W(30)) u_dut_b (
    .C100M(clk), .RESET_n(rst_n), .SW_IN(sw_in), .AS_CPU_n(as_n), .DTACK_CPU_n(dtack_n),
    .FORCE_SLOW(force_slow), .CPU_SPEED(speed_b), .TURBO_CLK(turbo_b),
    .BOOT_DONE(boot_b), .SWITCH_PENDING(pend_b));

  // Reference model: n = edges since reset release, run = edges the synchronised switch
  // has held its value, since = edges spent in the current speed mode.
  typedef struct packed {
    int         n;
    logic [1:0] s1;
    logic [1:0] s2;
    int         run;
    logic [1:0] state;
    logic [1:0] speed;
    int         since;
    logic       turbo;
    logic       boot;
    logic       pend;
  } model_t;

  typedef struct packed {
    logic [1:0] speed;
    logic       turbo;
    logic       boot;
    logic       pend;
  } exp_t;

  model_t ma, mb;
  exp_t   qa[$];
  exp_t   qb[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int hp_of(input logic [63:0] hp, input logic [1:0] k);
    return int'(hp[{k, 4'b0000} +: 16]);
  endfunction

  function automatic model_t reset_model();
    model_t r;
    r = '0;
    return r;
  endfunction

  function automatic model_t step(input model_t m, input logic [1:0] sw, input logic idle,
                                  input logic fs, input logic [63:0] hp);
    model_t     r;
    logic [1:0] target;
    int         h;
    bit         can;
    r      = m;
    target = (!m.boot || fs || hp_of(hp, m.state) == 0) ? 2'd0 : m.state;
    h      = hp_of(hp, m.speed);
    if (m.speed == 2'd0) can = idle;
    else can = idle && (m.since % h == h - 1) && ((m.since / h) % 2 == 0);
    if (can && target != m.speed) begin
      r.speed = target;
      r.since = 0;
    end else begin
      r.since = m.since + 1;
    end
    if (r.speed == 2'd0) r.turbo = 1'b0;
    else r.turbo = ((r.since / hp_of(hp, r.speed)) % 2) == 1;
    r.pend = (target != r.speed);
    r.n    = m.n + 1;
    r.boot = (r.n >= BOOT_LIM);
    r.s1   = sw;
    r.s2   = m.s1;
    r.run  = (m.s1 == m.s2) ? m.run + 1 : 1;
    if (r.s2 != m.state && r.run >= DB_LIM + 1) r.state = r.s2;
    return r;
  endfunction

  task automatic drive(input logic [1:0] sw, input logic an, input logic dn, input logic fs);
    sw_in      = sw;
    as_n       = an;
    dtack_n    = dn;
    force_slow = fs;
    @(posedge clk);
    if (!rst_n) begin
      ma = reset_model();
      mb = reset_model();
    end else begin
      ma = step(ma, sw, an & dn, fs, HP_A);
      mb = step(mb, sw, an & dn, fs, HP_B);
    end
    qa.push_back('{speed: ma.speed, turbo: ma.turbo, boot: ma.boot, pend: ma.pend});
    qb.push_back('{speed: mb.speed, turbo: mb.turbo, boot: mb.boot, pend: mb.pend});
    #2;
  endtask

  task automatic random_run(input int cycles);
    logic [1:0] sw_cur;
    logic [1:0] sw_drv;
    logic       fs;
    sw_cur = sw_in;
    fs     = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 49) == 0) sw_cur = 2'($urandom_range(0, 3));
      sw_drv = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : sw_cur;
      if ($urandom_range(0, 99) == 0) fs = ~fs;
      drive(sw_drv, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, fs);
    end
  endtask

  // Monitor: pops one expectation per clock and compares away from the active edge.
  initial begin
    exp_t ea, eb;
    forever begin
      @(negedge clk);
      if (qa.size() > 0 && qb.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("a_cpu_speed", 32'(speed_a), 32'(ea.speed));
        check("a_turbo_clk", 32'(turbo_a), 32'(ea.turbo));
        check("a_boot_done", 32'(boot_a),  32'(ea.boot));
        check("a_pending",   32'(pend_a),  32'(ea.pend));
        check("b_cpu_speed", 32'(speed_b), 32'(eb.speed));
        check("b_turbo_clk", 32'(turbo_b), 32'(eb.turbo));
        check("b_boot_done", 32'(boot_b),  32'(eb.boot));
        check("b_pending",   32'(pend_b),  32'(eb.pend));
      end
    end
  end

  initial begin
    bit seen_high;
    ma = reset_model();
    mb = reset_model();

    // Boot hold-off with the switch at 2.
    repeat (3) drive(2'd2, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (40) drive(2'd2, 1'b1, 1'b1, 1'b0);

    // Move to mode 1, then bounce 1/3 faster than the debounce window and settle on 3.
    repeat (25) drive(2'd1, 1'b1, 1'b1, 1'b0);
    repeat (3) drive(2'd3, 1'b1, 1'b1, 1'b0);
    repeat (3) drive(2'd1, 1'b1, 1'b1, 1'b0);
    repeat (30) drive(2'd3, 1'b1, 1'b1, 1'b0);

    // Switch accepted while the bus is busy, then released.
    repeat (20) drive(2'd2, 1'b0, 1'b1, 1'b0);
    repeat (20) drive(2'd2, 1'b1, 1'b1, 1'b0);

    // FORCE_SLOW pulse in mode 3, first with an idle bus, then during a bus cycle.
    repeat (25) drive(2'd3, 1'b1, 1'b1, 1'b0);
    repeat (10) drive(2'd3, 1'b1, 1'b1, 1'b1);
    repeat (10) drive(2'd3, 1'b1, 1'b1, 1'b0);
    repeat (5)  drive(2'd3, 1'b0, 1'b0, 1'b1);
    repeat (5)  drive(2'd3, 1'b1, 1'b1, 1'b1);
    repeat (10) drive(2'd3, 1'b1, 1'b1, 1'b0);

    random_run(1500);

    // Asynchronous reset between edges while TURBO_CLK is high.
    repeat (30) drive(2'd3, 1'b1, 1'b1, 1'b0);
    seen_high = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(2'd3, 1'b1, 1'b1, 1'b0);
      #4;
      if (turbo_a) begin
        seen_high = 1'b1;
        break;
      end
    end
    check("turbo_high_before_reset", 32'(seen_high), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_a_turbo", 32'(turbo_a), 32'd0);
    check("async_rst_a_speed", 32'(speed_a), 32'd0);
    check("async_rst_a_boot",  32'(boot_a),  32'd0);
    check("async_rst_a_pend",  32'(pend_a),  32'd0);
    check("async_rst_b_boot",  32'(boot_b),  32'd0);
    ma = reset_model();
    mb = reset_model();
    repeat (3) drive(2'd3, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (40) drive(2'd3, 1'b1, 1'b1, 1'b0);
    random_run(200);

    #10;
    check("scoreboard_drained", 32'(qa.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
